// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encodings,
// opcode constants and instruction field positions.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD_REG = 3'd2,
    ST_ALU      = 3'd3,
    ST_WB       = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_BRCC = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic is_alu_opcode(input logic [3:0] opc);
    return (opc >= 4'h1) && (opc <= 4'h7);
  endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter for the instruction sequencer: synchronous clear,
// load of a jump/branch target, and modulo-2^ADDR_W increment.
module seq_pc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: clear beats load beats increment; the add wraps naturally
  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH / LOAD_REG / ALU / WB control FSM.
// Define SEQ_TIMEOUT_EN to add a fetch watchdog that aborts a stalled fetch.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               condition_code,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               rf_rd_en,
  output logic               alu_en,
  output logic               rf_wr_en,
  output logic [2:0]         alu_op,
  output logic [2:0]         current_state,
  output logic               halted,
  output logic               fetch_err
);

  state_e               state_q;
  state_e               state_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [INSTR_W-1:0]   instr_d;
  logic                 pc_load_s;
  logic                 pc_inc_s;
  logic [ADDR_W-1:0]    pc_s;
  logic [3:0]           opc_s;
  logic                 timeout_s;
  logic                 unused_instr_s;

  assign opc_s          = get_opcode(instr_q);
  assign unused_instr_s = ^instr_q;

  seq_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .clr_i    (~rst_n),
    .load_i   (pc_load_s),
    .inc_i    (pc_inc_s),
    .target_i (instr_q[ADDR_W-1:0]),
    .pc_o     (pc_s)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            fetch_err_q;
  logic            fetch_err_d;

  // Watchdog: counts unacknowledged FETCH cycles, cleared whenever FETCH is left
  always_comb begin
    wd_d        = '0;
    fetch_err_d = 1'b0;
    timeout_s   = 1'b0;
    if ((state_q == ST_FETCH) && !imem_ack) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        timeout_s   = 1'b1;
        fetch_err_d = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end else begin
      wd_d = '0;
    end
  end

  // Watchdog counter and registered error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q        <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  localparam int unused_timeout_lp = TIMEOUT;

  assign timeout_s = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Next-state, instruction latch and PC control
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d  = imem_data;
          pc_inc_s = 1'b1;
          state_d  = ST_LOAD_REG;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_LOAD_REG: begin
        if (is_alu_opcode(opc_s)) begin
          state_d = ST_ALU;
        end else begin
          case (opc_s)
            OP_JMP: begin
              pc_load_s = 1'b1;
              state_d   = ST_FETCH;
            end
            OP_BRCC: begin
              pc_load_s = condition_code;
              state_d   = ST_FETCH;
            end
            OP_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_ALU: state_d = ST_WB;
      ST_WB: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_HALT: begin
        if (start) state_d = ST_HALT;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched instruction registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Moore output decode; strobes are one-hot by construction
  always_comb begin
    imem_req = 1'b0;
    rf_rd_en = 1'b0;
    alu_en   = 1'b0;
    rf_wr_en = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_FETCH:    imem_req = 1'b1;
      ST_LOAD_REG: rf_rd_en = 1'b1;
      ST_ALU:      alu_en   = 1'b1;
      ST_WB:       rf_wr_en = 1'b1;
      ST_HALT:     halted   = 1'b1;
      default:     imem_req = 1'b0;
    endcase
  end

  assign imem_addr     = pc_s;
  assign alu_op        = opc_s[2:0];
  assign current_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level reference model.
module tb_instr_sequencer;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;
  localparam int PC_MOD  = 1 << ADDR_W;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              condition_code = 1'b0;
  logic              imem_ack = 1'b0;
  logic [15:0]       imem_data = 16'h0000;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              rf_rd_en, alu_en, rf_wr_en;
  logic [2:0]        alu_op;
  logic [2:0]        current_state;
  logic              halted;
  logic              fetch_err;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .condition_code (condition_code),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .rf_rd_en       (rf_rd_en),
    .alu_en         (alu_en),
    .rf_wr_en       (rf_wr_en),
    .alu_op         (alu_op),
    .current_state  (current_state),
    .halted         (halted),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: phase number, PC, last fetched word, stalled-fetch count
  typedef struct {
    int st;
    int pc;
    int instr;
    int wd;
    bit err;
  } model_t;

  model_t m = '{st: 0, pc: 0, instr: 0, wd: 0, err: 1'b0};

  function automatic model_t model_step(model_t cur, bit rst_ok, bit run, bit cc,
                                        bit ack, int data);
    model_t nx = cur;
    int opc;
    nx.err = 1'b0;
    if (!rst_ok) return '{st: 0, pc: 0, instr: 0, wd: 0, err: 1'b0};
    case (cur.st)
      0: nx.st = run ? 1 : 0;
      1: begin
        if (ack) begin
          nx.instr = data;
          nx.pc    = (cur.pc + 1) % PC_MOD;
          nx.st    = 2;
          nx.wd    = 0;
        end else if (TO_EN && (cur.wd + 1 >= TIMEOUT)) begin
          nx.st  = 0;
          nx.err = 1'b1;
          nx.wd  = 0;
        end else begin
          nx.wd = cur.wd + 1;
        end
      end
      2: begin
        opc = cur.instr / 4096;
        if (opc >= 1 && opc <= 7) nx.st = 3;
        else if (opc == 15)       nx.st = 5;
        else                      nx.st = 1;
        if (opc == 9 || (opc == 8 && cc)) nx.pc = cur.instr % PC_MOD;
      end
      3: nx.st = 4;
      4: nx.st = run ? 1 : 0;
      5: nx.st = run ? 5 : 0;
      default: nx.st = 0;
    endcase
    return nx;
  endfunction

  // Advance the model on every rising edge from the same inputs the DUT sees
  always @(posedge clk) begin
    m <= model_step(m, rst_n, start, condition_code, imem_ack, int'(imem_data));
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", int'(current_state), m.st);
      chk("imem_addr", int'(imem_addr), m.pc);
      chk("imem_req", int'(imem_req), int'(m.st == 1));
      chk("rf_rd_en", int'(rf_rd_en), int'(m.st == 2));
      chk("alu_en", int'(alu_en), int'(m.st == 3));
      chk("rf_wr_en", int'(rf_wr_en), int'(m.st == 4));
      chk("halted", int'(halted), int'(m.st == 5));
      chk("fetch_err", int'(fetch_err), int'(m.err));
      chk("strobe_onehot", int'(imem_req) + int'(rf_rd_en) + int'(alu_en) + int'(rf_wr_en),
          (m.st >= 1 && m.st <= 4) ? 1 : 0);
      if (m.st == 3) chk("alu_op", int'(alu_op), (m.instr / 4096) % 8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; condition_code = 1'b0;
    imem_data = 16'h0000;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic fetch_word(input logic [15:0] w);
    imem_ack = 1'b1; imem_data = w;
    tick();
    imem_ack = 1'b0; imem_data = 16'h0000;
  endtask

  int r;

  initial begin
    // Reset with start low: idle and silent for five cycles
    do_reset(3);
    chk_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_state", int'(current_state), 0);
      chk("rst_addr", int'(imem_addr), 0);
      chk("rst_strobes", int'({imem_req, rf_rd_en, alu_en, rf_wr_en}), 0);
    end

    // ALU instruction with a two-cycle fetch stall
    start = 1'b1;
    tick(); chk("alu_seq0", int'(current_state), 1);
    tick(); chk("alu_seq1", int'(current_state), 1);
    tick(); chk("alu_seq2", int'(current_state), 1);
    fetch_word(16'h3005); chk("alu_seq3", int'(current_state), 2);
    tick(); chk("alu_seq4", int'(current_state), 3);
    chk("alu_op_lit", int'(alu_op), 3);
    tick(); chk("alu_seq5", int'(current_state), 4);
    chk("wb_strobe", int'(rf_wr_en), 1);
    tick(); chk("alu_seq6", int'(current_state), 1);
    chk("pc_after_alu", int'(imem_addr), 1);
    chk("wb_one_cycle", int'(rf_wr_en), 0);

    // Branch not taken, then taken
    do_reset(1);
    start = 1'b1;
    tick();
    fetch_word(16'h8042); chk("brcc0_noalu", int'(alu_en), 0);
    tick(); chk("brcc_nt_state", int'(current_state), 1);
    chk("brcc_nt_pc", int'(imem_addr), 1);
    fetch_word(16'h8042);
    condition_code = 1'b1;
    tick(); chk("brcc_t_state", int'(current_state), 1);
    chk("brcc_t_pc", int'(imem_addr), 8'h42);
    chk("brcc1_noalu", int'(alu_en), 0);
    condition_code = 1'b0;

    // PC wrap at the top of the address space, then HALT
    do_reset(1);
    start = 1'b1;
    tick();
    fetch_word(16'h90FF);
    tick(); chk("jmp_pc", int'(imem_addr), 8'hFF);
    fetch_word(16'h0000); chk("wrap_pc", int'(imem_addr), 0);
    tick();
    fetch_word(16'hF000);
    tick(); chk("halt_hi0", int'(halted), 1);
    tick(); chk("halt_hi1", int'(halted), 1);
    start = 1'b0;
    tick(); chk("halt_exit", int'(current_state), 0);
    chk("halt_pc_kept", int'(imem_addr), 1);

    // Reset in FETCH with a coincident ack
    do_reset(1);
    start = 1'b1;
    tick(); tick();
    rst_n = 1'b0; imem_ack = 1'b1; imem_data = 16'h3005;
    tick();
    chk("rstf_state", int'(current_state), 0);
    chk("rstf_req", int'(imem_req), 0);
    chk("rstf_pc", int'(imem_addr), 0);
    rst_n = 1'b1; imem_ack = 1'b0; start = 1'b0;
    tick();

    // Stalled fetch: watchdog abort when enabled, otherwise wait indefinitely
    do_reset(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("stall_still_fetch", int'(current_state), 1);
    tick();
    chk("stall_state", int'(current_state), TO_EN ? 0 : 1);
    chk("stall_err", int'(fetch_err), TO_EN ? 1 : 0);
    chk("stall_pc", int'(imem_addr), 0);
    tick();
    chk("stall_err_pulse", int'(fetch_err), 0);

    // Randomized traffic checked by the model every cycle
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      rst_n          = (r != 0);
      start          = ($urandom_range(0, 3) != 0);
      condition_code = $urandom_range(0, 1) != 0;
      imem_ack       = ($urandom_range(0, 99) < ((i % 1000 < 900) ? 40 : 2));
      imem_data      = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: program counter and instruction-memory address width.
REQ-002 Parameter TIMEOUT, default 15: fetch watchdog limit in cycles; used only when SEQ_TIMEOUT_EN is defined.
REQ-003 clk  in  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1: reset, synchronous, active-low.
REQ-005 start  in  1: run request; level-sensitive.
REQ-006 condition_code  in  1: branch condition from the datapath flags.
REQ-007 imem_req  out  1: instruction fetch request.
REQ-008 imem_addr  out  ADDR_W: fetch address, equal to the program counter (PC).
REQ-009 imem_ack  in  1: fetch complete; imem_data valid in the same cycle.
REQ-010 imem_data  in  16: instruction; [15:12] opcode, [ADDR_W-1:0] target.
REQ-011 rf_rd_en, alu_en, rf_wr_en  out  1 each: register-read, ALU-execute and writeback strobes.
REQ-012 alu_op  out  3: ALU operation, opcode[2:0] of the latched instruction.
REQ-013 current_state  out  3: state encoding, for debug.
REQ-014 halted  out  1: high while in HALT.
REQ-015 fetch_err  out  1: one-cycle pulse on fetch timeout.

Function
REQ-016 States SHALL be IDLE=0, FETCH=1, LOAD_REG=2, ALU=3, WB=4, HALT=5; Moore outputs decoded from the state register.
REQ-017 IDLE: start=1 -> FETCH next cycle; otherwise hold; PC unchanged.
REQ-018 FETCH: imem_req=1, imem_addr=PC held stable until imem_ack; on ack, latch imem_data, PC<=PC+1 modulo 2^ADDR_W, -> LOAD_REG.
REQ-019 LOAD_REG: rf_rd_en=1 for exactly one cycle; next state decoded from the latched opcode.
REQ-020 Opcodes 0x1-0x7 -> ALU; 0x0 (NOP) -> FETCH; 0x9 (JMP): PC<=target, -> FETCH; 0xF (HALT) -> HALT; other opcodes treated as NOP.
REQ-021 0x8 (BRCC): if condition_code=1 in the LOAD_REG cycle, PC<=target; always -> FETCH.
REQ-022 ALU: alu_en=1, alu_op valid, one cycle, -> WB.
REQ-023 WB: rf_wr_en=1 for one cycle; start=1 -> FETCH, start=0 -> IDLE.
REQ-024 HALT: halted=1; hold while start=1; start=0 -> IDLE; PC retained.
REQ-025 start is sampled only in IDLE, WB and HALT; deasserting it mid-instruction SHALL NOT abort the instruction.
REQ-026 PC=2^ADDR_W-1 fetch SHALL wrap PC to 0 with no error.
REQ-027 At most one of imem_req, rf_rd_en, alu_en, rf_wr_en SHALL be high in any cycle.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, PC=0, latched instruction=0, watchdog=0, all outputs 0 in the following cycle, from any state.
REQ-029 Reset during FETCH SHALL drop imem_req the next cycle; an imem_ack coincident with reset SHALL be ignored.

Configuration
REQ-030 With SEQ_TIMEOUT_EN defined: a cycle counter runs in FETCH; reaching TIMEOUT cycles without imem_ack -> IDLE, fetch_err pulses one cycle, PC unchanged; counter clears on leaving FETCH.
REQ-031 Without SEQ_TIMEOUT_EN: FETCH waits indefinitely; fetch_err tied 0; no counter logic.

Structure
REQ-032 Shared package seq_pkg SHALL hold the state encodings, opcode constants and instruction field positions.
REQ-033 One sub-module, seq_pc: PC register with synchronous clear, load (target) and increment; the controller instantiates it once.

Verification
REQ-034 Reset 0..2 cycles, start=0 -> state 0, all strobes 0, imem_addr=0 for 5 cycles.
REQ-035 start=1, imem_ack after 2 cycles with data 0x3005 -> states 1,1,1,2,3,4,1; alu_op=3; PC=1; rf_wr_en high 1 cycle.
REQ-036 Fetch 0x8042 with condition_code=0, then with condition_code=1 -> PC=1 the first time, 0x42 the second; no alu_en either time.
REQ-037 PC=0xFF, fetch 0x0000 -> PC=0x00; fetch 0xF000 -> halted=1 while start=1; start=0 -> state 0.
REQ-038 Reset asserted in FETCH while imem_ack=1 -> next cycle state 0, imem_req=0, PC=0.
REQ-039 SEQ_TIMEOUT_EN, TIMEOUT=15, imem_ack held 0 -> after 15 FETCH cycles state 0, fetch_err pulses once, PC unchanged.
